// File: rtl/universal_counter_param_if.sv
// -----------------------------------------------------------------------------
// universal_counter_param_if
//   Groups the control, configuration and status signals of the universal
//   counter. Clock and reset are kept as plain ports on the counter itself.
//
//   Signals (controller -> counter):
//     Enable      synchronous clock enable
//     Mode        00 hold, 01 count, 10 reverse, 11 parallel load
//     Bounce      0 = wrap at the bounds, 1 = reflect at the bounds
//     Step        count increment/decrement magnitude
//     P           parallel load value
//     BeginCount  lower bound (inclusive)
//     EndCount    upper bound (inclusive)
//   Signals (counter -> controller):
//     Q              registered count
//     Dir            registered direction, 1 = up
//     TerminalCount  registered one-cycle pulse after a bound crossing
//     ConfigError    BeginCount > EndCount (combinational)
//
//   Modports: master = controller side, slave = counter side.
// -----------------------------------------------------------------------------
interface universal_counter_param_if #(
  parameter int WIDTH      = 10,
  parameter int STEP_WIDTH = 4
);
  logic                  Enable;
  logic [1:0]            Mode;
  logic                  Bounce;
  logic [STEP_WIDTH-1:0] Step;
  logic [WIDTH-1:0]      P;
  logic [WIDTH-1:0]      BeginCount;
  logic [WIDTH-1:0]      EndCount;
  logic [WIDTH-1:0]      Q;
  logic                  Dir;
  logic                  TerminalCount;
  logic                  ConfigError;

  modport master (
    output Enable, Mode, Bounce, Step, P, BeginCount, EndCount,
    input  Q, Dir, TerminalCount, ConfigError
  );

  modport slave (
    input  Enable, Mode, Bounce, Step, P, BeginCount, EndCount,
    output Q, Dir, TerminalCount, ConfigError
  );
endinterface

// File: rtl/universal_counter_param.sv
// -----------------------------------------------------------------------------
// universal_counter_param
//   Up/down/load counter with programmable step, wrap or bounce behaviour at
//   the bounds and an internal direction register. Used for ball and paddle
//   positions and for timing dividers in the display datapath.
//
//   Ports:
//     CLOCK  system clock, all state changes on the rising edge
//     Reset  asynchronous active-low reset; loads Q with BeginCount, Dir = up
//     bus    universal_counter_param_if.slave (control in, status out)
//
//   Direction register:
//     Dir | meaning
//     ----+-------------------------------
//      1  | counting up towards EndCount
//      0  | counting down towards BeginCount
//
//   Constraint: STEP_WIDTH < WIDTH.
// -----------------------------------------------------------------------------
module universal_counter_param #(
  parameter int WIDTH      = 10,
  parameter int STEP_WIDTH = 4
) (
  input  logic                      CLOCK,
  input  logic                      Reset,
  universal_counter_param_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_HOLD    = 2'b00,
    MODE_COUNT   = 2'b01,
    MODE_REVERSE = 2'b10,
    MODE_LOAD    = 2'b11
  } mode_t;

  logic [WIDTH-1:0] qReg;
  logic             dirReg;
  logic             tcReg;

  logic [WIDTH-1:0] qNext;
  logic             dirNext;
  logic             tcNext;

  logic             configError;

  // Bound comparisons are done one bit wider than the counter so that
  // Q+Step and BeginCount+Step never wrap before they are compared.
  logic [WIDTH-1:0] stepNarrow;
  logic [WIDTH:0]   stepExt;
  logic [WIDTH:0]   qExt;
  logic [WIDTH:0]   beginExt;
  logic [WIDTH:0]   endExt;
  logic [WIDTH:0]   upSum;
  logic [WIDTH:0]   beginPlusStep;

  // Narrow results are only selected on the non-crossing path, where the
  // wide compare has already shown they cannot wrap.
  logic [WIDTH-1:0] qPlusStep;
  logic [WIDTH-1:0] qMinusStep;

  assign stepNarrow    = {{(WIDTH-STEP_WIDTH){1'b0}}, bus.Step};
  assign stepExt       = {1'b0, stepNarrow};
  assign qExt          = {1'b0, qReg};
  assign beginExt      = {1'b0, bus.BeginCount};
  assign endExt        = {1'b0, bus.EndCount};
  assign upSum         = qExt + stepExt;
  assign beginPlusStep = beginExt + stepExt;
  assign qPlusStep     = qReg + stepNarrow;
  assign qMinusStep    = qReg - stepNarrow;

  assign configError   = (bus.BeginCount > bus.EndCount);

  always_comb begin
    qNext   = qReg;
    dirNext = dirReg;
    tcNext  = 1'b0;

    case (mode_t'(bus.Mode))
      MODE_LOAD: begin
        // Out-of-range loads are accepted; the next count edge resolves them
        // as an ordinary crossing.
        qNext = bus.P;
      end

      MODE_REVERSE: begin
        dirNext = ~dirReg;
      end

      MODE_COUNT: begin
        if ((stepNarrow != '0) && !configError) begin
          if (dirReg) begin
            if (bus.Bounce) begin
              if (upSum >= endExt) begin
                qNext   = bus.EndCount;
                dirNext = 1'b0;
                tcNext  = 1'b1;
              end else begin
                qNext = qPlusStep;
              end
            end else begin
              if (upSum > endExt) begin
                qNext  = bus.BeginCount;
                tcNext = 1'b1;
              end else begin
                qNext = qPlusStep;
              end
            end
          end else begin
            if (bus.Bounce) begin
              if (qExt <= beginPlusStep) begin
                qNext   = bus.BeginCount;
                dirNext = 1'b1;
                tcNext  = 1'b1;
              end else begin
                qNext = qMinusStep;
              end
            end else begin
              if (qExt < beginPlusStep) begin
                qNext  = bus.EndCount;
                tcNext = 1'b1;
              end else begin
                qNext = qMinusStep;
              end
            end
          end
        end
      end

      default: begin
      end
    endcase
  end

  // Reset loads the live lower bound so the first count starts from it.
  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      qReg   <= bus.BeginCount;
      dirReg <= 1'b1;
      tcReg  <= 1'b0;
    end else if (bus.Enable) begin
      qReg   <= qNext;
      dirReg <= dirNext;
      tcReg  <= tcNext;
    end else begin
      tcReg  <= 1'b0;
    end
  end

  assign bus.Q             = qReg;
  assign bus.Dir           = dirReg;
  assign bus.TerminalCount = tcReg;
  assign bus.ConfigError   = configError;

endmodule

// File: doc/universal_counter_param.md
Name: universal_counter_param

Overview:
- Parametrised next-generation up/down/load counter for the pong display datapath: ball X/Y position, paddle position, timing dividers.
- Adds a programmable step size, two end-of-range modes (wrap or bounce/reflect) and an internal direction register.
- Adds a reverse command so game logic can flip direction on a paddle hit.
- Provides a registered single-cycle terminal-count pulse and a configuration error flag.

Parameters:
- WIDTH, 10, counter and bound width in bits.
- STEP_WIDTH, 4, width of the Step input.

Ports:
- CLOCK  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Enable  input  1  synchronous clock enable; when 0, all state (Q, Dir, TerminalCount) holds, TerminalCount forced 0.
- Mode  input  2  00 hold, 01 count, 10 reverse, 11 parallel load.
- Bounce  input  1  0 = wrap at bounds, 1 = reflect at bounds.
- Step  input  STEP_WIDTH  increment/decrement magnitude.
- P  input  WIDTH  parallel load value.
- BeginCount  input  WIDTH  lower bound (inclusive).
- EndCount  input  WIDTH  upper bound (inclusive).
- Q  output  WIDTH  registered count.
- Dir  output  1  registered direction; 1 = up, 0 = down.
- TerminalCount  output  1  registered one-cycle pulse; bound crossed on the previous edge.
- ConfigError  output  1  combinational; 1 when BeginCount > EndCount.

Behaviour:
- Reset low (asynchronous): Q = BeginCount (live input value), Dir = 1, TerminalCount = 0. Release is synchronous to the next CLOCK edge, with no special treatment.
- All arithmetic is in WIDTH+1 bits; no comparison may be corrupted by overflow or underflow.
- Every edge with Enable = 1 clears TerminalCount unless a crossing occurs on that edge.
- Mode 00: Q and Dir hold.
- Mode 11: Q <= P, Dir unchanged, no TerminalCount. P outside [BeginCount, EndCount] is accepted; the next count resolves it as a crossing.
- Mode 10: Dir <= ~Dir, Q holds, no TerminalCount.
- Mode 01, Step = 0: Q holds, no TerminalCount.
- Mode 01, ConfigError = 1: Q and Dir hold, no TerminalCount.
- Mode 01, Dir = 1, Bounce = 0:
  - Q+Step > EndCount: Q <= BeginCount, TerminalCount <= 1.
  - Otherwise: Q <= Q+Step.
- Mode 01, Dir = 1, Bounce = 1:
  - Q+Step >= EndCount: Q <= EndCount, Dir <= 0, TerminalCount <= 1.
  - Otherwise: Q <= Q+Step.
- Mode 01, Dir = 0, Bounce = 0:
  - Q < BeginCount+Step: Q <= EndCount, TerminalCount <= 1.
  - Otherwise: Q <= Q-Step.
- Mode 01, Dir = 0, Bounce = 1:
  - Q <= BeginCount+Step: Q <= BeginCount, Dir <= 1, TerminalCount <= 1.
  - Otherwise: Q <= Q-Step.
- Latency: Q, Dir and TerminalCount all update on the same edge. TerminalCount is high for exactly the cycle in which Q shows the post-crossing value.
- A Bounce change mid-count takes effect on the next count edge; Dir is retained.
- BeginCount == EndCount, count with Step >= 1:
  - Wrap mode: Q stays at the bound and TerminalCount pulses every count cycle.
  - Bounce mode: Q stays at the bound, Dir toggles and TerminalCount pulses every count cycle.
- A mid-operation reset overrides everything immediately, including a pending TerminalCount.

Test Plan:
- Wrap up: WIDTH=10, Begin=10, End=20, Step=3, Bounce=0, Mode=01 after reset -> Q = 10, 13, 16, 19, 10 with TerminalCount high only with the second 10; Dir stays 1.
- Bounce: same bounds, Bounce=1 -> Q = 10, 13, 16, 19, 20 (Dir->0, TC), 17, 14, 11, 10 (Dir->1, TC), 13; TerminalCount high exactly 2 cycles.
- Load/reverse/enable: load P=500 with Begin=10, End=20, Bounce=0, Dir=1 -> Q = 500, next count gives Q = 10 with TC. Then Mode=10 -> Dir = 0, Q holds, no TC. Enable=0 for 5 cycles with Mode=01 -> Q, Dir, TC frozen.
- Overflow boundary: WIDTH=10, Begin=0, End=1023, Step=15, Q loaded 1020, wrap -> Q = 0 with TC, no spurious value from 10-bit overflow. Down from Q=5 -> Q = 1023 with TC.
- Config/degenerate: Begin=30, End=20, Mode=01 -> ConfigError = 1, Q holds, no TC. Begin=End=7 in bounce mode -> Q = 7, TC every cycle, Dir toggling.
- Async reset: assert Reset low mid-cycle while TC=1, Q=20, Dir=0 -> immediately Q = BeginCount, Dir = 1, TC = 0 without waiting for an edge. Counting resumes on the first edge after release.
